// File: rtl/up_alu_mux_ram_if.sv
// Datapath bus between the processor control unit and up_alu_mux_ram.
// ALU_CARRY_EN adds the alu_c carry/borrow flag.
interface up_alu_mux_ram_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 7
);
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [1:0]        alu_op;
  logic [ADDR_W-1:0] m3;
  logic [ADDR_W-1:0] m2;
  logic [ADDR_W-1:0] m1;
  logic [ADDR_W-1:0] m0;
  logic [1:0]        sel;
  logic              le;
  logic              mx_memio;
  logic [DATA_W-1:0] inport;
  logic [DATA_W-1:0] alu_out;
  logic              alu_z;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] mem_out;
`ifdef ALU_CARRY_EN
  logic              alu_c;
`endif

  modport master (
`ifdef ALU_CARRY_EN
    input  alu_c,
`endif
    output a, b, alu_op, m3, m2, m1, m0, sel, le, mx_memio, inport,
    input  alu_out, alu_z, addr, mem_out
  );

  modport slave (
`ifdef ALU_CARRY_EN
    output alu_c,
`endif
    input  a, b, alu_op, m3, m2, m1, m0, sel, le, mx_memio, inport,
    output alu_out, alu_z, addr, mem_out
  );
endinterface

// File: rtl/up_alu_mux_ram.sv
// Processor datapath core: 2-bit-op ALU, 4:1 address mux and 128x16 RAM with async read.
// Define ALU_CARRY_EN to drive the alu_c carry/borrow flag.
module up_alu_mux_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 7
) (
  input logic               clk,
  input logic               reset,
  up_alu_mux_ram_if.slave   bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   dif_ext;
  logic [DATA_W-1:0] alu_res;
  logic              carry;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata;

  // One extra bit holds carry-out of the add and borrow of the subtract.
  assign sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
  assign dif_ext = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    alu_res = '0;
    carry   = 1'b0;
    unique case (bus.alu_op)
      2'b00: begin
        alu_res = sum_ext[DATA_W-1:0];
        carry   = sum_ext[DATA_W];
      end
      2'b01: begin
        alu_res = dif_ext[DATA_W-1:0];
        carry   = dif_ext[DATA_W];
      end
      2'b10: alu_res = bus.a;
      2'b11: alu_res = bus.a & bus.b;
      default: ;
    endcase
  end

  always_comb begin
    addr_sel = bus.m0;
    unique case (bus.sel)
      2'b11: addr_sel = bus.m3;
      2'b10: addr_sel = bus.m2;
      2'b01: addr_sel = bus.m1;
      2'b00: addr_sel = bus.m0;
      default: ;
    endcase
  end

  assign wdata = bus.mx_memio ? bus.inport : alu_res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.le) begin
      mem_q[addr_sel] <= wdata;
    end
  end

  assign bus.alu_out = alu_res;
  assign bus.alu_z   = (alu_res == '0);
  assign bus.addr    = addr_sel;
  assign bus.mem_out = mem_q[addr_sel];

`ifdef ALU_CARRY_EN
  assign bus.alu_c = carry;
`else
  logic unused_carry;
  assign unused_carry = carry;
`endif
endmodule

// File: tb/tb_up_alu_mux_ram.sv
// Scoreboard bench for up_alu_mux_ram: directed plan then random traffic against a word-level model.
module tb_up_alu_mux_ram;
  logic clk;
  logic reset;

  up_alu_mux_ram_if #(.DATA_W(16), .ADDR_W(7)) bus ();

  up_alu_mux_ram #(.DATA_W(16), .ADDR_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    alu;
    int    z;
    int    addr;
    int    mem;
    int    c;
  } exp_t;

  exp_t q[$];
  int   model[128];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, midway between stimulus and write edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".alu_out"}, 32'(bus.alu_out), e.alu);
        chk({e.nm, ".alu_z"}, 32'(bus.alu_z), e.z);
        chk({e.nm, ".addr"}, 32'(bus.addr), e.addr);
        chk({e.nm, ".mem_out"}, 32'(bus.mem_out), e.mem);
`ifdef ALU_CARRY_EN
        chk({e.nm, ".alu_c"}, 32'(bus.alu_c), e.c);
`endif
      end
    end
  end

  task automatic step(input string nm, input bit rst_v, input logic [15:0] av, input logic [15:0] bv,
                      input logic [1:0] opv, input logic [6:0] m3v, input logic [6:0] m2v,
                      input logic [6:0] m1v, input logic [6:0] m0v, input logic [1:0] selv,
                      input bit lev, input bit mxv, input logic [15:0] inv);
    exp_t e;
    int   r;
    int   c;
    int   ad;
    int   srcs[4];
    reset        = rst_v;
    bus.a        = av;
    bus.b        = bv;
    bus.alu_op   = opv;
    bus.m3       = m3v;
    bus.m2       = m2v;
    bus.m1       = m1v;
    bus.m0       = m0v;
    bus.sel      = selv;
    bus.le       = lev;
    bus.mx_memio = mxv;
    bus.inport   = inv;
    if (!rst_v) begin
      for (int i = 0; i < 128; i++) model[i] = 0;
    end
    c = 0;
    case (opv)
      2'd0: begin
        r = (int'(av) + int'(bv)) % 65536;
        c = (int'(av) + int'(bv) > 65535) ? 1 : 0;
      end
      2'd1: begin
        r = (int'(av) - int'(bv) + 65536) % 65536;
        c = (int'(av) < int'(bv)) ? 1 : 0;
      end
      2'd2: r = int'(av);
      default: r = int'(av & bv);
    endcase
    srcs[0] = int'(m0v);
    srcs[1] = int'(m1v);
    srcs[2] = int'(m2v);
    srcs[3] = int'(m3v);
    ad = srcs[selv];
    e.nm   = nm;
    e.alu  = r;
    e.z    = (r == 0) ? 1 : 0;
    e.addr = ad;
    e.mem  = model[ad];
    e.c    = c;
    q.push_back(e);
    @(posedge clk);
    if (rst_v && lev) model[ad] = mxv ? int'(inv) : r;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Reset behaviour: write attempt while held in reset, then reads after release.
    step("rst_wr5", 0, 16'h1111, 16'h2222, 2'b00, 7'h00, 7'h00, 7'h00, 7'd5, 2'b00, 1, 0, 16'h0);
    step("rst_rd5", 1, 16'h0, 16'h0, 2'b10, 7'h00, 7'h00, 7'h00, 7'd5, 2'b00, 0, 0, 16'h0);
    step("rst_rd0", 1, 16'h0, 16'h0, 2'b10, 7'h00, 7'h00, 7'h00, 7'd0, 2'b00, 0, 0, 16'h0);
    step("rst_rd1", 1, 16'h0, 16'h0, 2'b10, 7'h00, 7'h00, 7'h00, 7'd1, 2'b00, 0, 0, 16'h0);
    step("rst_rd127", 1, 16'h0, 16'h0, 2'b10, 7'h00, 7'h00, 7'h00, 7'd127, 2'b00, 0, 0, 16'h0);
    // ALU corners.
    step("add_ovf", 1, 16'h7FFF, 16'h0001, 2'b00, 7'h0, 7'h0, 7'h0, 7'h0, 2'b00, 0, 0, 16'h0);
    step("add_wrap", 1, 16'hFFFF, 16'h0001, 2'b00, 7'h0, 7'h0, 7'h0, 7'h0, 2'b00, 0, 0, 16'h0);
    step("sub_neg", 1, 16'd5, 16'd7, 2'b01, 7'h0, 7'h0, 7'h0, 7'h0, 2'b00, 0, 0, 16'h0);
    step("pass_a", 1, 16'd5, 16'd7, 2'b10, 7'h0, 7'h0, 7'h0, 7'h0, 2'b00, 0, 0, 16'h0);
    step("and_ab", 1, 16'hF0F0, 16'h0FF0, 2'b11, 7'h0, 7'h0, 7'h0, 7'h0, 2'b00, 0, 0, 16'h0);
    // Address mux.
    for (int s = 3; s >= 0; s--) begin
      step($sformatf("mux_sel%0d", s), 1, 16'h0, 16'h0, 2'b10, 7'h7F, 7'h2A, 7'h7E, 7'h03,
           2'(s), 0, 0, 16'h0);
    end
    // ALU write path, then I/O write path.
    step("wr_alu", 1, 16'h1234, 16'h0, 2'b10, 7'h0, 7'h2A, 7'h0, 7'h0, 2'b10, 1, 0, 16'hDEAD);
    step("rd_alu", 1, 16'h0, 16'h0, 2'b10, 7'h0, 7'h2A, 7'h0, 7'h0, 2'b10, 0, 0, 16'h0);
    step("wr_io", 1, 16'h5555, 16'h0, 2'b00, 7'h0, 7'h0, 7'h7E, 7'h0, 2'b01, 1, 1, 16'hBEEF);
    step("rd_io", 1, 16'h0, 16'h0, 2'b10, 7'h0, 7'h0, 7'h7E, 7'h0, 2'b01, 0, 0, 16'h0);
    step("rd_keep", 1, 16'h0, 16'h0, 2'b10, 7'h0, 7'h2A, 7'h0, 7'h0, 2'b10, 0, 0, 16'h0);
    // Carry / borrow corners.
    step("c_add", 1, 16'hFFFF, 16'd1, 2'b00, 7'h0, 7'h0, 7'h0, 7'h0, 2'b00, 0, 0, 16'h0);
    step("c_sub_b", 1, 16'd3, 16'd5, 2'b01, 7'h0, 7'h0, 7'h0, 7'h0, 2'b00, 0, 0, 16'h0);
    step("c_sub_nb", 1, 16'd5, 16'd3, 2'b01, 7'h0, 7'h0, 7'h0, 7'h0, 2'b00, 0, 0, 16'h0);
    // Random traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      step($sformatf("rnd%0d", n), ($urandom_range(0, 49) != 0),
           16'($urandom), 16'($urandom), 2'($urandom), 7'($urandom), 7'($urandom),
           7'($urandom), 7'($urandom), 2'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 1) == 1), 16'($urandom));
    end
    bus.le = 1'b0;
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/up_alu_mux_ram.md
Name: up_alu_mux_ram

Overview:
- Datapath core of the simple 16-bit processor: 2-bit-op ALU, 4:1 address multiplexer and 128x16 data/program RAM.
- The surrounding control unit owns all architectural registers (IR, A, B, PC, SP, FZ) and feeds them in.
- The block returns ALU result, ALU zero flag, selected address and memory read data.

Parameters:
- DATA_W, 16, data/word width of ALU, RAM and I/O input.
- ADDR_W, 7, address width; RAM depth is 2**ADDR_W = 128 words.

Ports:
- clk  input  1  system clock, rising edge active.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- a  input  DATA_W  ALU operand A.
- b  input  DATA_W  ALU operand B.
- alu_op  input  2  ALU operation select.
- m3  input  ADDR_W  address source 3 (IR[6:0], destination field).
- m2  input  ADDR_W  address source 2 (IR[13:7], source field).
- m1  input  ADDR_W  address source 1 (SP).
- m0  input  ADDR_W  address source 0 (PC).
- sel  input  2  address mux select.
- le  input  1  RAM write enable.
- mx_memio  input  1  write-data select: 1 = inport, 0 = ALU result.
- inport  input  DATA_W  external input-port data.
- alu_out  output  DATA_W  ALU result (combinational).
- alu_z  output  1  1 when alu_out == 0 (combinational).
- addr  output  ADDR_W  selected RAM address (combinational).
- mem_out  output  DATA_W  RAM word at addr (combinational read).

Behaviour:
- ALU, all arithmetic modulo 2**DATA_W:
  - 00: a + b.
  - 01: a - b (two's complement).
  - 10: pass a.
  - 11: a & b.
- alu_z = (alu_out == 0), valid for every op.
- Address mux:
  - sel 11 -> m3; 10 -> m2; 01 -> m1; 00 -> m0.
  - Pure combinational, no latching.
- Write data: wdata = mx_memio ? inport : alu_out.
- RAM write:
  - On rising clk with reset=1 and le=1: mem[addr] <= wdata.
  - le=0: no write.
- RAM read:
  - mem_out = mem[addr], asynchronous, zero latency.
  - Read-during-write returns old data until the clock edge, new data immediately after it.
- Addresses span the full 0..127 range. No out-of-range case, no wrap logic needed.
- Reset:
  - reset=0 asynchronously clears all 128 words to 0.
  - While reset=0, writes are ignored and mem_out reads 0.
  - Deassertion takes effect at the next edge. The first write can occur at the first rising clk with reset=1.
  - Reset mid-operation discards any write in that cycle.
- No other state. alu_out, alu_z and addr do not depend on reset.

Optional Feature:
- ALU_CARRY_EN defined:
  - Adds output port alu_c (1 bit).
  - Op 00: carry-out of a+b.
  - Op 01: borrow (1 when a < b unsigned).
  - Ops 10/11: 0.
- ALU_CARRY_EN undefined: port alu_c absent. All other behaviour identical.

Test Plan:
- Reset: drive reset=0, then reset=1. Read addresses 0, 1, 127 via sel=00/m0 -> mem_out=0x0000. Pulse le=1 with reset=0 at m0=5 -> mem[5] still 0x0000.
- ALU: a=0x7FFF, b=0x0001, op 00 -> 0x8000, z=0. a=0xFFFF, b=0x0001, op 00 -> 0x0000, z=1. a=5, b=7, op 01 -> 0xFFFE, z=0. op 10 -> 0x0005. a=0xF0F0, b=0x0FF0, op 11 -> 0x00F0.
- Mux:
  - Stimulus: m3=0x7F, m2=0x2A, m1=0x7E, m0=0x03, sel 11/10/01/00.
  - Response: addr = 0x7F/0x2A/0x7E/0x03.
- Write/read ALU path:
  - Stimulus: sel=10, m2=0x2A, mx_memio=0, a=0x1234, op 10, le=1 for one edge.
  - Response: mem_out=0x1234 after the edge. Before the edge mem_out showed the old value 0x0000.
- Write/read I/O path:
  - Stimulus: sel=01, m1=0x7E, mx_memio=1, inport=0xBEEF, le=1 for one edge.
  - Response: mem_out at 0x7E = 0xBEEF. Address 0x2A unchanged at 0x1234.
- ALU_CARRY_EN:
  - a=0xFFFF, b=1, op 00 -> alu_c=1.
  - a=3, b=5, op 01 -> alu_c=1.
  - a=5, b=3, op 01 -> alu_c=0.
